led_fader: RTL and testbench

LED_FADER -- requirements
Module: led_fader

---
 rtl/led_fader.sv | 138 +++++++++++++
 tb/tb_led_fader.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/led_fader.sv
// Five-channel LED fader: each channel ramps an 8-bit brightness level up or down
// at a prescaled tick rate toward its requested on/off target, driving PWM outputs.
module led_fader #(
  parameter int STEP_DIV = 47_059
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [4:0] led_req,
  input  logic       enable,
  output logic       LED1,
  output logic       LED2,
  output logic       LED3,
  output logic       LED4,
  output logic       LED5,
  output logic       busy
);

  localparam int          NCH       = 5;
  localparam logic [19:0] PRESC_MAX = 20'(STEP_DIV - 1);
  localparam logic [7:0]  PWM_MAX   = 8'd254;

  localparam logic [1:0] S_OFF  = 2'd0;
  localparam logic [1:0] S_RISE = 2'd1;
  localparam logic [1:0] S_ON   = 2'd2;
  localparam logic [1:0] S_FALL = 2'd3;

  function automatic logic [7:0] sat_inc(input logic [7:0] l);
    return (l == 8'd255) ? 8'd255 : l + 8'd1;
  endfunction

  function automatic logic [7:0] sat_dec(input logic [7:0] l);
    return (l == 8'd0) ? 8'd0 : l - 8'd1;
  endfunction

  logic [19:0] presc_p0;
  logic        tick;
  logic [7:0]  pwm_cnt_p0;
  logic [7:0]  level      [NCH];
  logic [7:0]  level_nxt  [NCH];
  logic [1:0]  state      [NCH];
  logic [1:0]  state_nxt  [NCH];
  logic [4:0]  led_p1;
  logic        any_ramp;

  // Stage 0: step prescaler and free-running PWM counter
  assign tick = enable && (presc_p0 == PRESC_MAX);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      presc_p0 <= '0;
    end else if (enable) begin
      presc_p0 <= tick ? '0 : presc_p0 + 20'd1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pwm_cnt_p0 <= '0;
    end else begin
      pwm_cnt_p0 <= (pwm_cnt_p0 == PWM_MAX) ? 8'd0 : pwm_cnt_p0 + 8'd1;
    end
  end

  // Direction reversal wins over a coincident tick, so the level never jumps on a flip
  always_comb begin
    for (int n = 0; n < NCH; n++) begin
      state_nxt[n] = state[n];
      level_nxt[n] = level[n];
      if (enable) begin
        case (state[n])
          S_OFF: begin
            if (led_req[n]) state_nxt[n] = S_RISE;
          end
          S_RISE: begin
            if (!led_req[n]) begin
              state_nxt[n] = S_FALL;
            end else if (tick) begin
              level_nxt[n] = sat_inc(level[n]);
              if (level[n] >= 8'd254) state_nxt[n] = S_ON;
            end
          end
          S_ON: begin
            if (!led_req[n]) state_nxt[n] = S_FALL;
          end
          default: begin
            if (led_req[n]) begin
              state_nxt[n] = S_RISE;
            end else if (tick) begin
              level_nxt[n] = sat_dec(level[n]);
              if (level[n] <= 8'd1) state_nxt[n] = S_OFF;
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int n = 0; n < NCH; n++) begin
        state[n] <= S_OFF;
        level[n] <= 8'd0;
      end
    end else begin
      for (int n = 0; n < NCH; n++) begin
        state[n] <= state_nxt[n];
        level[n] <= level_nxt[n];
      end
    end
  end

  always_comb begin
    any_ramp = 1'b0;
    for (int n = 0; n < NCH; n++) begin
      if (state[n] == S_RISE || state[n] == S_FALL) any_ramp = 1'b1;
    end
  end

  // Stage 1: registered PWM compare and busy flag
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      led_p1 <= '0;
      busy   <= 1'b0;
    end else begin
      for (int n = 0; n < NCH; n++) begin
        led_p1[n] <= enable && (pwm_cnt_p0 < level[n]);
      end
      if (enable) busy <= any_ramp;
    end
  end

  assign LED1 = led_p1[0];
  assign LED2 = led_p1[1];
  assign LED3 = led_p1[2];
  assign LED4 = led_p1[3];
  assign LED5 = led_p1[4];

endmodule

// File: tb/tb_led_fader.sv
// Directed bench for led_fader: a STEP_DIV=1 instance for ramp/reset/freeze cases
// and a slower instance for the PWM duty-cycle measurement.
module tb_led_fader;

  localparam logic [1:0] OFF  = 2'd0;
  localparam logic [1:0] RISE = 2'd1;
  localparam logic [1:0] ON   = 2'd2;
  localparam logic [1:0] FALL = 2'd3;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic [4:0] led_req;
  logic       enable;
  logic       LED1, LED2, LED3, LED4, LED5, busy;
  logic [4:0] leds;

  logic       rst2_n;
  logic [4:0] req2;
  logic       en2;
  logic       L2_1, L2_2, L2_3, L2_4, L2_5, busy2;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  always #5 CLK = ~CLK;

  assign leds = {LED5, LED4, LED3, LED2, LED1};

  led_fader #(.STEP_DIV(1)) u1 (
    .CLK(CLK), .RST_N(RST_N), .led_req(led_req), .enable(enable),
    .LED1(LED1), .LED2(LED2), .LED3(LED3), .LED4(LED4), .LED5(LED5), .busy(busy)
  );

  led_fader #(.STEP_DIV(300)) u2 (
    .CLK(CLK), .RST_N(rst2_n), .led_req(req2), .enable(en2),
    .LED1(L2_1), .LED2(L2_2), .LED3(L2_3), .LED4(L2_4), .LED5(L2_5), .busy(busy2)
  );

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    int bad;
    int highs;
    int found;

    RST_N   = 1'b1;
    led_req = 5'b11111;
    enable  = 1'b1;
    rst2_n  = 1'b0;
    req2    = 5'b00001;
    en2     = 1'b1;

    // Reset asserted with all requests high
    #2 RST_N = 1'b0;
    #1;
    chk("rst_leds_now", 32'(leds), 32'd0);
    chk("rst_busy_now", 32'(busy), 32'd0);
    step(3);
    chk("rst_leds_hold", 32'(leds), 32'd0);
    chk("rst_busy_hold", 32'(busy), 32'd0);
    chk("rst_level0", 32'(u1.level[0]), 32'd0);

    // Full ramp of channel 0
    led_req = 5'b00001;
    RST_N   = 1'b1;
    step(1);
    chk("ramp_state_e1", 32'(u1.state[0]), 32'(RISE));
    chk("ramp_level_e1", 32'(u1.level[0]), 32'd0);
    chk("ramp_busy_e1", 32'(busy), 32'd0);
    step(1);
    chk("ramp_level_e2", 32'(u1.level[0]), 32'd1);
    chk("ramp_busy_e2", 32'(busy), 32'd1);
    step(254);
    chk("ramp_level_top", 32'(u1.level[0]), 32'd255);
    chk("ramp_state_on", 32'(u1.state[0]), 32'(ON));
    chk("ramp_busy_last", 32'(busy), 32'd1);
    step(1);
    chk("ramp_busy_done", 32'(busy), 32'd0);
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      if (leds !== 5'b00001) bad++;
      step(1);
    end
    chk("ramp_led_const", 32'(bad), 32'd0);
    chk("ramp_level_stay", 32'(u1.level[0]), 32'd255);

    // Asynchronous reset in the middle of ramps
    led_req = 5'b00010;
    step(10);
    chk("mid_busy_pre", 32'(busy), 32'd1);
    chk("mid_led1_pre", 32'(LED1), 32'd1);
    #2 RST_N = 1'b0;
    #1;
    chk("mid_leds", 32'(leds), 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_level0", 32'(u1.level[0]), 32'd0);
    chk("mid_state1", 32'(u1.state[1]), 32'(OFF));

    // Reversal at level 100
    led_req = 5'b00001;
    step(1);
    RST_N = 1'b1;
    step(101);
    chk("rev_level_100", 32'(u1.level[0]), 32'd100);
    led_req = 5'b00000;
    step(1);
    chk("rev_flip_level", 32'(u1.level[0]), 32'd100);
    chk("rev_flip_state", 32'(u1.state[0]), 32'(FALL));
    step(1);
    chk("rev_level_99", 32'(u1.level[0]), 32'd99);
    step(1);
    chk("rev_level_98", 32'(u1.level[0]), 32'd98);
    step(97);
    chk("rev_level_1", 32'(u1.level[0]), 32'd1);
    step(1);
    chk("rev_level_0", 32'(u1.level[0]), 32'd0);
    chk("rev_state_off", 32'(u1.state[0]), 32'(OFF));
    step(1);
    chk("rev_busy_done", 32'(busy), 32'd0);
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      if (leds !== 5'b00000) bad++;
      step(1);
    end
    chk("rev_led_const0", 32'(bad), 32'd0);

    // Enable freeze on channel 3
    led_req = 5'b00100;
    step(61);
    chk("frz_level_60", 32'(u1.level[2]), 32'd60);
    enable = 1'b0;
    bad = 0;
    for (int i = 0; i < 500; i++) begin
      step(1);
      if (LED3 !== 1'b0 || u1.level[2] !== 8'd60) bad++;
    end
    chk("frz_hold", 32'(bad), 32'd0);
    chk("frz_state", 32'(u1.state[2]), 32'(RISE));
    chk("frz_busy_held", 32'(busy), 32'd1);
    enable = 1'b1;
    step(1);
    chk("frz_resume_61", 32'(u1.level[2]), 32'd61);

    // Simultaneous reversal on channel 2 and start on channel 5 during a tick
    led_req = 5'b00110;
    step(11);
    chk("sim_ch2_level", 32'(u1.level[1]), 32'd10);
    led_req = 5'b10100;
    step(1);
    chk("sim_ch2_flip_level", 32'(u1.level[1]), 32'd10);
    chk("sim_ch2_state", 32'(u1.state[1]), 32'(FALL));
    chk("sim_ch5_state", 32'(u1.state[4]), 32'(RISE));
    chk("sim_ch5_level", 32'(u1.level[4]), 32'd0);
    chk("sim_ch3_level", 32'(u1.level[2]), 32'd73);
    step(1);
    chk("sim_ch2_next", 32'(u1.level[1]), 32'd9);
    chk("sim_ch5_next", 32'(u1.level[4]), 32'd1);

    // Duty cycle at level 128 on the slower instance
    rst2_n = 1'b1;
    found = 0;
    for (int i = 0; i < 60000; i++) begin
      step(1);
      if (u2.level[0] == 8'd128) begin
        found = 1;
        break;
      end
    end
    chk("duty_reach_128", 32'(found), 32'd1);
    highs = 0;
    for (int i = 0; i < 255; i++) begin
      step(1);
      if (L2_1 === 1'b1) highs++;
    end
    chk("duty_high_cycles", 32'(highs), 32'd128);
    chk("duty_level_still", 32'(u2.level[0]), 32'd128);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
